// File: rtl/mem_master.sv
// Memory test master: writes an incrementing pattern over a window, reads it back,
// and reports the mismatch count and the first failing address.
module mem_master #(
    parameter int ADDR_WIDTH = 9,
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 512
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic [WIDTH-1:0]      seed_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  wr_rd_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH:0]   err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     offset_q, offset_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [WIDTH-1:0]        seed_q, seed_d;
    logic [ADDR_WIDTH:0]     err_q, err_d;
    logic [ADDR_WIDTH-1:0]   first_q, first_d;
    logic                    pass_q, pass_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]        wdata_q, wdata_d;

    logic [ADDR_WIDTH:0]     len_clamp;
    logic [ADDR_WIDTH:0]     off_inc;
    logic [WIDTH-1:0]        pattern;
    logic                    last_xfer;

    always_comb begin
        len_clamp = (len_i > DEPTH_L) ? DEPTH_L : len_i;
        off_inc   = offset_q + ONE_L;
        pattern   = seed_q + WIDTH'(offset_q);
        last_xfer = (off_inc == len_q);

        state_d  = state_q;
        offset_d = offset_q;
        len_d    = len_q;
        base_d   = base_q;
        seed_d   = seed_q;
        err_d    = err_q;
        first_d  = first_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                wr_d    = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                if (start_i) begin
                    base_d   = base_addr_i;
                    seed_d   = seed_i;
                    len_d    = len_clamp;
                    offset_d = '0;
                    err_d    = '0;
                    first_d  = '0;
                    pass_d   = 1'b0;
                    if (len_clamp == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = WRITE;
                        valid_d = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = base_addr_i;
                        wdata_d = seed_i;
                    end
                end
            end
            WRITE: begin
                if (ready_i) begin
                    if (last_xfer) begin
                        // Turn straight around into the read pass, no idle cycle.
                        state_d  = READ;
                        offset_d = '0;
                        wr_d     = 1'b0;
                        addr_d   = base_q;
                        wdata_d  = '0;
                    end else begin
                        offset_d = off_inc;
                        addr_d   = base_q + ADDR_WIDTH'(off_inc);
                        wdata_d  = seed_q + WIDTH'(off_inc);
                    end
                end
            end
            READ: begin
                if (ready_i) begin
                    if (rdata_i != pattern) begin
                        err_d = err_q + ONE_L;
                        if (err_q == '0) begin
                            first_d = addr_q;
                        end
                    end
                    if (last_xfer) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        addr_d  = '0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        offset_d = off_inc;
                        addr_d   = base_q + ADDR_WIDTH'(off_inc);
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                offset_d = '0;
                valid_d  = 1'b0;
                wr_d     = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            offset_q <= '0;
            len_q    <= '0;
            base_q   <= '0;
            seed_q   <= '0;
            err_q    <= '0;
            first_q  <= '0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            len_q    <= len_d;
            base_q   <= base_d;
            seed_q   <= seed_d;
            err_q    <= err_d;
            first_q  <= first_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign addr_o           = addr_q;
    assign wdata_o          = wdata_q;
    assign wr_rd_o          = wr_q;
    assign valid_o          = valid_q;
    assign busy_o           = (state_q != IDLE);
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: a table of runs against a simple memory with an
// optional stuck bit, plus hand sequences for reset-at-power-up and mid-run reset.
module tb_mem_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [8:0]  base_addr_i;
    logic [9:0]  len_i;
    logic [15:0] seed_i;
    logic [8:0]  addr_o;
    logic [15:0] wdata_o;
    logic        wr_rd_o;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] rdata_i;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic [9:0]  err_count_o;
    logic [8:0]  first_err_addr_o;

    mem_master #(.ADDR_WIDTH(9), .WIDTH(16), .DEPTH(512)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .len_i(len_i), .seed_i(seed_i), .addr_o(addr_o), .wdata_o(wdata_o),
        .wr_rd_o(wr_rd_o), .valid_o(valid_o), .ready_i(ready_i), .rdata_i(rdata_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_count_o(err_count_o),
        .first_err_addr_o(first_err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    // Target memory; cur_fault selects an address whose bit 0 reads back flipped
    // (10'h200 is outside the address space, meaning no fault).
    logic [15:0] mem [0:511];
    logic [9:0]  cur_fault = 10'h200;
    int          wr_count  = 0;

    assign rdata_i = mem[addr_o] ^ (({1'b0, addr_o} == cur_fault) ? 16'h0001 : 16'h0000);

    always @(posedge clk_i) begin
        if (start_i && !busy_o && !rst_i) begin
            wr_count <= 0;
        end else if (valid_o && ready_i && wr_rd_o) begin
            mem[addr_o] <= wdata_o;
            wr_count    <= wr_count + 1;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [8:0]  base;
        logic [9:0]  len;
        logic [15:0] seed;
        logic [9:0]  fault;
        int          stall_idx;
        int          stall_n;
        bit          mid_start;
        int          exp_cycles;
        logic        exp_pass;
        logic [9:0]  exp_err;
        logic [8:0]  exp_first;
        int          exp_writes;
    } vec_t;

    vec_t vecs [9];

    initial begin
        //          base  len    seed      fault  stall   mid  cyc   pass err first writes
        vecs[0] = '{9'd0,   10'd4,   16'h1000, 10'h200, -1, 0, 0, 9,    1'b1, 10'd0, 9'd0,   4};
        vecs[1] = '{9'd510, 10'd4,   16'hABCD, 10'h200, -1, 0, 0, 9,    1'b1, 10'd0, 9'd0,   4};
        vecs[2] = '{9'd0,   10'd8,   16'h0055, 10'd5,   -1, 0, 0, 17,   1'b0, 10'd1, 9'd5,   8};
        vecs[3] = '{9'd7,   10'd0,   16'h1234, 10'h200, -1, 0, 0, 1,    1'b1, 10'd0, 9'd0,   0};
        vecs[4] = '{9'd0,   10'd4,   16'h2000, 10'h200,  1, 3, 0, 12,   1'b1, 10'd0, 9'd0,   4};
        vecs[5] = '{9'd3,   10'd600, 16'hFFFF, 10'd2,   -1, 0, 0, 1025, 1'b0, 10'd1, 9'd2,   512};
        vecs[6] = '{9'd0,   10'd4,   16'h1000, 10'h200, -1, 0, 1, 9,    1'b1, 10'd0, 9'd0,   4};
        vecs[7] = '{9'd100, 10'd3,   16'h0000, 10'd200, -1, 0, 0, 7,    1'b1, 10'd0, 9'd0,   3};
        vecs[8] = '{9'd511, 10'd1,   16'h0007, 10'd511, -1, 0, 0, 3,    1'b0, 10'd1, 9'd511, 1};

        rst_i = 1'b1; start_i = 1'b0; ready_i = 1'b1;
        base_addr_i = '0; len_i = '0; seed_i = '0;
        repeat (2) @(negedge clk_i);
        chk("reset valid", {31'd0, valid_o}, 32'd0);
        chk("reset busy",  {31'd0, busy_o},  32'd0);
        chk("reset done",  {31'd0, done_o},  32'd0);
        chk("reset pass",  {31'd0, pass_o},  32'd0);
        chk("reset outs",  {wdata_o, addr_o, wr_rd_o, 6'd0}, 32'd0);
        chk("reset err",   {22'd0, err_count_o}, 32'd0);
        chk("reset first", {23'd0, first_err_addr_o}, 32'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 9; i++) begin
            vec_t v;
            int   cyc, xfer, stall_cnt, seq_bad, eff, off;
            logic        e_wr;
            logic [8:0]  e_addr;
            logic [15:0] e_wdata;
            logic [9:0]  held_err;
            logic        held_pass;
            v = vecs[i];
            cur_fault = v.fault;
            @(negedge clk_i);
            base_addr_i = v.base; len_i = v.len; seed_i = v.seed;
            start_i = 1'b1; ready_i = 1'b1;
            xfer = 0; stall_cnt = 0; seq_bad = 0; cyc = 0;
            eff = v.exp_writes;
            for (int c = 1; c <= 2000; c++) begin
                @(negedge clk_i);
                cyc = c;
                if (v.mid_start && c == 3) begin
                    start_i = 1'b1; base_addr_i = 9'd300; len_i = 10'd1; seed_i = 16'h5555;
                end else begin
                    start_i = 1'b0;
                end
                if (done_o) break;
                if (valid_o) begin
                    if (xfer < eff) begin
                        e_wr = 1'b1; off = xfer; e_wdata = v.seed + 16'(off);
                    end else begin
                        e_wr = 1'b0; off = xfer - eff; e_wdata = 16'h0000;
                    end
                    e_addr = v.base + 9'(off);
                    if (xfer >= 2 * eff || wr_rd_o !== e_wr || addr_o !== e_addr || wdata_o !== e_wdata) begin
                        if (seq_bad == 0)
                            $display("FAIL vec%0d xfer%0d: got wr=%0b addr=%0d wdata=%0h, expected wr=%0b addr=%0d wdata=%0h",
                                     i, xfer, wr_rd_o, addr_o, wdata_o, e_wr, e_addr, e_wdata);
                        seq_bad++;
                    end
                    if (xfer == v.stall_idx && stall_cnt < v.stall_n) begin
                        ready_i = 1'b0; stall_cnt++;
                    end else begin
                        ready_i = 1'b1; xfer++;
                    end
                end else begin
                    ready_i = 1'b1;
                end
                cyc = 2001;
            end
            start_i = 1'b0; ready_i = 1'b1;
            chk($sformatf("vec%0d done cycle", i), 32'(cyc), 32'(v.exp_cycles));
            chk($sformatf("vec%0d sequence errors", i), 32'(seq_bad), 32'd0);
            chk($sformatf("vec%0d pass", i), {31'd0, pass_o}, {31'd0, v.exp_pass});
            chk($sformatf("vec%0d err_count", i), {22'd0, err_count_o}, {22'd0, v.exp_err});
            chk($sformatf("vec%0d first_err", i), {23'd0, first_err_addr_o}, {23'd0, v.exp_first});
            chk($sformatf("vec%0d writes", i), 32'(wr_count), 32'(v.exp_writes));
            chk($sformatf("vec%0d valid at done", i), {31'd0, valid_o}, 32'd0);
            held_err = err_count_o; held_pass = pass_o;
            @(negedge clk_i);
            chk($sformatf("vec%0d done pulse", i), {31'd0, done_o}, 32'd0);
            @(negedge clk_i);
            chk($sformatf("vec%0d idle busy", i), {31'd0, busy_o}, 32'd0);
            chk($sformatf("vec%0d held result", i), {21'd0, held_pass, held_err},
                {21'd0, v.exp_pass, v.exp_err});
            chk($sformatf("vec%0d held now", i), {21'd0, pass_o, err_count_o},
                {21'd0, v.exp_pass, v.exp_err});
        end

        // Reset in the middle of a write pass aborts the run for good.
        begin
            int stray;
            cur_fault = 10'h200;
            @(negedge clk_i);
            base_addr_i = 9'd0; len_i = 10'd4; seed_i = 16'h1000; start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
            @(negedge clk_i);
            chk("midrst in write", {30'd0, valid_o, wr_rd_o}, 32'd3);
            rst_i = 1'b1;
            repeat (2) @(negedge clk_i);
            rst_i = 1'b0;
            @(negedge clk_i);
            chk("midrst valid", {31'd0, valid_o}, 32'd0);
            chk("midrst busy",  {31'd0, busy_o},  32'd0);
            chk("midrst done",  {31'd0, done_o},  32'd0);
            chk("midrst err",   {22'd0, err_count_o}, 32'd0);
            stray = 0;
            repeat (6) begin
                @(negedge clk_i);
                if (valid_o || done_o || busy_o) stray++;
            end
            chk("midrst no restart", 32'(stray), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 The block SHALL use a single clock and a reset that is synchronous and active-high.
REQ-002 Parameters, one per line:
  ADDR_WIDTH, 9, address bits
  WIDTH, 16, data word bits
  DEPTH, 512, words in target memory (= 2**ADDR_WIDTH)
REQ-003 Ports, one per line:
  clk_i  in  1  clock, all logic on rising edge
  rst_i  in  1  synchronous active-high reset
  start_i  in  1  begin test run (sampled only in IDLE)
  base_addr_i  in  ADDR_WIDTH  first address of run
  len_i  in  ADDR_WIDTH+1  word count, 0..DEPTH
  seed_i  in  WIDTH  pattern seed
  addr_o  out  ADDR_WIDTH  memory address
  wdata_o  out  WIDTH  memory write data
  wr_rd_o  out  1  1 = write, 0 = read
  valid_o  out  1  request valid
  ready_i  in  1  memory accepts request / read data valid
  rdata_i  in  WIDTH  memory read data, valid when valid_o & ready_i & !wr_rd_o
  busy_o  out  1  run in progress
  done_o  out  1  one-cycle end-of-run pulse
  pass_o  out  1  last run had zero mismatches
  err_count_o  out  ADDR_WIDTH+1  mismatches in last run
  first_err_addr_o  out  ADDR_WIDTH  address of first mismatch, 0 if none

Function
REQ-004 The FSM SHALL have states IDLE, WRITE, READ and DONE.
REQ-005 In IDLE with start_i=1, the block SHALL latch base_addr_i, seed_i and len_i, clearing err_count_o, pass_o and first_err_addr_o; len_i>DEPTH SHALL be clamped to DEPTH.
REQ-006 On start with latched len=0, the FSM SHALL go IDLE->DONE with no memory request and pass_o=1.
REQ-007 On start with len>0, the FSM SHALL go to WRITE with offset=0.
REQ-008 A transfer SHALL complete only on a cycle where valid_o=1 and ready_i=1.
REQ-009 Per transfer: addr_o=(base+offset) mod 2**ADDR_WIDTH (wraps 511->0); pattern=(seed+offset) mod 2**WIDTH.
REQ-010 In WRITE: valid_o=1, wr_rd_o=1, wdata_o=pattern.
REQ-011 In READ: valid_o=1, wr_rd_o=0, wdata_o=0.
REQ-012 While valid_o=1 and ready_i=0, addr_o, wdata_o and wr_rd_o SHALL hold stable; no offset SHALL be skipped or repeated.
REQ-013 Each completed transfer SHALL increment offset; the last write SHALL move the FSM to READ with offset=0 next cycle, keeping valid_o high with no idle gap.
REQ-014 Each completed read SHALL compare rdata_i to the pattern in that cycle; on mismatch it SHALL increment err_count_o, and on the first mismatch it SHALL capture addr_o into first_err_addr_o.
REQ-015 The last completed read SHALL move the FSM to DONE.
REQ-016 DONE SHALL last one cycle with done_o=1 and valid_o=0, set pass_o=(err_count_o==0) including the final read's result, then return to IDLE.
REQ-017 busy_o SHALL be 1 in WRITE, READ and DONE.
REQ-018 start_i SHALL be ignored outside IDLE.
REQ-019 With ready_i always 1, done_o SHALL assert exactly 2*len+1 cycles after the start_i sampling edge.
REQ-020 pass_o, err_count_o and first_err_addr_o SHALL hold their values until the next accepted start.

Reset
REQ-021 rst_i=1 at any clock edge SHALL force IDLE, offset=0, and all outputs 0 (valid_o, wr_rd_o, addr_o, wdata_o, busy_o, done_o, pass_o, err_count_o, first_err_addr_o).
REQ-022 Reset mid-run SHALL abort with no done_o pulse; the first request after reset SHALL require a new start_i.

Verification
REQ-023 Reset: rst_i=1 for 2 cycles during a WRITE -> next cycle valid_o=0, busy_o=0, done_o=0, err_count_o=0.
REQ-024 Ideal memory (ready_i=1), base=0, len=4, seed=16'h1000 -> writes to addr 0..3 with data 1000..1003 on consecutive cycles, then 4 reads, done_o at cycle 9, pass_o=1.
REQ-025 Wrap: base=510, len=4 -> addr_o sequence 510, 511, 0, 1 for both writes and reads; pass_o=1.
REQ-026 Backpressure: ready_i=0 for 3 cycles on the 2nd write -> addr_o=1 and wdata_o=seed+1 held for 4 cycles; all 4 addresses written exactly once.
REQ-027 Fault: memory model flips bit 0 of addr 5, base=0, len=8 -> pass_o=0, err_count_o=1, first_err_addr_o=5.
REQ-028 len=0 -> done_o one cycle after start and pass_o=1; start_i pulsed mid-run -> ignored, run unchanged.
